// File: rtl/outstanding_store_tracker.sv
// -----------------------------------------------------------------------------
// outstanding_store_tracker
//
// Purpose:
//   Counts stores that have been issued to the data cache but not yet
//   acknowledged. It throttles issue when the in-flight limit is reached and
//   services fence/drain requests. A drain completes once every outstanding
//   store has been acknowledged. A flush abandons a pending drain.
//
// Optional feature:
//   OST_WATCHDOG_EN - when defined, adds a watchdog counter. The counter raises
//                     a sticky timeout_o flag if stores stay outstanding for
//                     TimeoutCycles cycles without any acknowledge. When
//                     undefined, timeout_o is tied to 0.
//
// Parameters:
//   MaxOutstandingStores - in-flight store limit (default 7)
//   TimeoutCycles        - watchdog threshold in cycles (default 1024)
//
// Ports:
//   clk_i           in   clock, rising edge
//   rst_ni          in   asynchronous active-low reset
//   issue_valid_i   in   store unit offers one store
//   issue_ready_o   out  tracker accepts the offered store
//   ack_i           in   cache acknowledges one store completion
//   fence_req_i     in   fence/drain request (level)
//   flush_i         in   pipeline flush, cancels a pending fence
//   fence_ack_o     out  one-cycle pulse: drain complete
//   count_o         out  current number of outstanding stores
//   empty_o         out  count_o == 0
//   full_o          out  count_o == MaxOutstandingStores
//   underflow_err_o out  sticky: acknowledge seen with nothing outstanding
//   timeout_o       out  sticky watchdog flag
// -----------------------------------------------------------------------------
module outstanding_store_tracker #(
  parameter int MaxOutstandingStores = 7,
  parameter int TimeoutCycles        = 1024,
  localparam int CntWidth            = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic                ack_i,
  input  logic                fence_req_i,
  input  logic                flush_i,
  output logic                fence_ack_o,
  output logic [CntWidth-1:0] count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                underflow_err_o,
  output logic                timeout_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstandingStores);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                underflow_q;
  logic                issue_fire;
  logic                ack_eff;
  logic                ack_underflow;

  // Bounded up/down step. The count never passes the in-flight limit and
  // never wraps below zero, even if the gating upstream were bypassed.
  function automatic logic [CntWidth-1:0] step_count(
    input logic [CntWidth-1:0] cur,
    input logic                inc,
    input logic                dec
  );
    logic [CntWidth-1:0] res;
    res = cur;
    if (inc && !dec) begin
      res = (cur == CntMax) ? cur : cur + CntWidth'(1);
    end else if (!inc && dec) begin
      res = (cur == '0) ? cur : cur - CntWidth'(1);
    end
    return res;
  endfunction

  assign count_o         = count_q;
  assign empty_o         = (count_q == '0);
  assign full_o          = (count_q == CntMax);
  assign underflow_err_o = underflow_q;

  // Ready depends only on registered state, so there is no combinational
  // path from the request or acknowledge inputs to it.
  assign issue_ready_o = !full_o && (state_q == IDLE);
  assign issue_fire    = issue_valid_i && issue_ready_o;

  // An acknowledge with nothing outstanding is flagged and otherwise ignored.
  assign ack_eff       = ack_i && (count_q != '0);
  assign ack_underflow = ack_i && (count_q == '0);

  assign count_d = step_count(count_q, issue_fire, ack_eff);

  // Fence FSM next state. A flush always wins over drain completion, so a
  // flushed fence never produces an acknowledge.
  always_comb begin
    state_d     = state_q;
    fence_ack_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fence_req_i && !flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          fence_ack_o = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      underflow_q <= underflow_q | ack_underflow;
    end
  end

`ifdef OST_WATCHDOG_EN
  localparam int WdWidth = $clog2(TimeoutCycles + 1);
  localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TimeoutCycles);

  logic [WdWidth-1:0] wd_q, wd_d;
  logic               timeout_q;

  function automatic logic [WdWidth-1:0] sat_inc_wd(input logic [WdWidth-1:0] cur);
    return (cur == WdLimit) ? cur : cur + WdWidth'(1);
  endfunction

  // Watchdog measures time since the last sign of progress. Progress means an
  // effective acknowledge or nothing outstanding.
  always_comb begin
    wd_d = sat_inc_wd(wd_q);
    if (ack_eff || (count_q == '0)) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_q | (wd_d == WdLimit);
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_outstanding_store_tracker.sv
// -----------------------------------------------------------------------------
// tb_outstanding_store_tracker
//
// Self-checking bench for outstanding_store_tracker.
// - A table of per-cycle vectors holds the inputs and the expected outputs for
//   that cycle.
// - Expected records go into a scoreboard queue when the inputs are driven.
//   They are popped and compared once the outputs have settled.
// - Hand-written sequences cover reset values, reset during a drain, and the
//   watchdog.
// -----------------------------------------------------------------------------
module tb_outstanding_store_tracker;

  localparam int MaxOut  = 7;
  localparam int Timeout = 16;
  localparam int CntW    = $clog2(MaxOut + 1);

  logic            clk;
  logic            rst_n;
  logic            issue_valid;
  logic            issue_ready;
  logic            ack;
  logic            fence_req;
  logic            flush;
  logic            fence_ack;
  logic [CntW-1:0] count;
  logic            empty;
  logic            full;
  logic            underflow_err;
  logic            timeout;

  int n_chk;
  int n_fail;

  outstanding_store_tracker #(
    .MaxOutstandingStores(MaxOut),
    .TimeoutCycles       (Timeout)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .ack_i          (ack),
    .fence_req_i    (fence_req),
    .flush_i        (flush),
    .fence_ack_o    (fence_ack),
    .count_o        (count),
    .empty_o        (empty),
    .full_o         (full),
    .underflow_err_o(underflow_err),
    .timeout_o      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            iv;
    logic            ak;
    logic            fe;
    logic            fl;
    logic [CntW-1:0] cnt;
    logic            rdy;
    logic            full;
    logic            empty;
    logic            fack;
    logic            uf;
    string           name;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic iv, input logic ak, input logic fe, input logic fl,
                              input int cnt, input logic rdy, input logic fack, input logic uf,
                              input string name);
    vec_t v;
    v.iv    = iv;
    v.ak    = ak;
    v.fe    = fe;
    v.fl    = fl;
    v.cnt   = CntW'(cnt);
    v.rdy   = rdy;
    v.full  = (cnt == MaxOut);
    v.empty = (cnt == 0);
    v.fack  = fack;
    v.uf    = uf;
    v.name  = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input vec_t e);
    chk({e.name, ".count"},     32'(count),         32'(e.cnt));
    chk({e.name, ".ready"},     32'(issue_ready),   32'(e.rdy));
    chk({e.name, ".full"},      32'(full),          32'(e.full));
    chk({e.name, ".empty"},     32'(empty),         32'(e.empty));
    chk({e.name, ".fence_ack"}, 32'(fence_ack),     32'(e.fack));
    chk({e.name, ".underflow"}, 32'(underflow_err), 32'(e.uf));
    chk({e.name, ".timeout"},   32'(timeout),       32'(0));
  endtask

  task automatic drive(input logic iv, input logic ak, input logic fe, input logic fl);
    issue_valid = iv;
    ack         = ak;
    fence_req   = fe;
    flush       = fl;
  endtask

  initial begin
    vec_t e;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0);

    // Each row gives the inputs held for one cycle and the expected outputs
    // in that same cycle, before the next rising edge.
    // Fill to the limit, then hold an extra valid at full.
    for (int k = 0; k < MaxOut; k++) tbl.push_back(mk(1, 0, 0, 0, k, 1, 0, 0, "issue"));
    tbl.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, "full_hold"));
    tbl.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, "eighth_blocked"));
    // Acknowledge down to 3.
    tbl.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, "ack_down7"));
    tbl.push_back(mk(0, 1, 0, 0, 6, 1, 0, 0, "ack_down6"));
    tbl.push_back(mk(0, 1, 0, 0, 5, 1, 0, 0, "ack_down5"));
    tbl.push_back(mk(0, 1, 0, 0, 4, 1, 0, 0, "ack_down4"));
    // Issue and acknowledge in the same cycle at count 3.
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, "issue_ack_same"));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, "count_kept"));
    tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, "ack_to_2"));
    // Fence at count 2, then acknowledges at +2 and +4.
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0, "fence_req"));
    tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, "drain_wait"));
    tbl.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0, "drain_ack1"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, "drain_mid"));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, "drain_ack2"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, "fence_ack"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, "back_idle"));
    // Acknowledge at count 0 sets the sticky underflow flag.
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, "ack_at_zero"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, "underflow_set"));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, "issue_ack_zero"));
    // Flush during a drain at count 1.
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, "fence_at_1"));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, "flush_drain"));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, "idle_after_flush"));
    // Flush has priority over a drain that would complete in the same cycle.
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, "fence_at_0"));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, "flush_beats_done"));
    // A fence at count 0 is acknowledged one cycle later. A fence still held
    // during DRAIN is ignored.
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, "fence_again"));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, "fence_ack_1cyc"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, "idle_end"));

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.fence_ack", 32'(fence_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", 32'(issue_ready), 1);
    chk("rel.full", 32'(full), 0);
    chk("rel.empty", 32'(empty), 1);
    chk("rel.underflow", 32'(underflow_err), 0);
    chk("rel.timeout", 32'(timeout), 0);

    // Table-driven vectors through the scoreboard.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].ak, tbl[i].fe, tbl[i].fl);
      sb.push_back(tbl[i]);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk_vec(e);
      end
    end

    // Reset asserted in the middle of a drain aborts it.
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 0);
    #1;
    chk("rd.count_before", 32'(count), 1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("rd.in_drain", 32'(issue_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rd.count", 32'(count), 0);
    chk("rd.ready", 32'(issue_ready), 1);
    chk("rd.fence_ack", 32'(fence_ack), 0);
    chk("rd.underflow", 32'(underflow_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rd.no_fence_ack", 32'(fence_ack), 0);
      chk("rd.idle_ready", 32'(issue_ready), 1);
    end

    // Watchdog: one store stays outstanding with no acknowledge.
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("wd.count", 32'(count), 1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0);
      @(posedge clk);
      #1;
`ifdef OST_WATCHDOG_EN
      chk($sformatf("wd.timeout_c%0d", k), 32'(timeout), 32'(k >= Timeout));
`else
      chk($sformatf("wd.timeout_c%0d", k), 32'(timeout), 0);
`endif
    end
    chk("wd.count_held", 32'(count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
